// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and types for the VGA sync generator
// and the character/graphics generator that consumes its coordinates.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;

    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    localparam int VGA_H_TOT =
        VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOT =
        VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_HS_START = VGA_H_VIS + VGA_H_FP;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
    localparam int VGA_VS_START = VGA_V_VIS + VGA_V_FP;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_bus_t;

    function automatic logic in_span(
        input coord_t v,
        input coord_t lo,
        input coord_t hi
    );
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Tick-enabled shift register that delays the sync bundle so it lines up
// with the pixel data coming out of the graphics pipeline.
module sync_delay_line
    import vga_pkg::*;
#(
    parameter int        DEPTH   = 2,
    parameter sync_bus_t RST_VAL = '0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  sync_bus_t din,
    output sync_bus_t dout
);

    sync_bus_t stage_q [DEPTH];
    sync_bus_t stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (en) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel tick divider, scan counters,
// registered sync/blank decode and a delayed copy for the connector.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 1,
    parameter int H_VIS    = VGA_H_VIS,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_VIS    = VGA_V_VIS,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               p_tick,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               hsync_d,
    output logic               vsync_d,
    output logic               video_on_d,
    output logic               frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_tot
        $error("vga_sync_gen: H_TOT/V_TOT exceed 10-bit counters");
    end
    if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be 1..8");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_dly
        $error("vga_sync_gen: PIPE_DLY must be 0..4");
    end

    localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS_C  = coord_t'(H_VIS);
    localparam coord_t V_VIS_C  = coord_t'(V_VIS);
    localparam coord_t HS_START = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_END   = coord_t'(H_VIS + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_END   = coord_t'(V_VIS + V_FP + V_SYNC);

    localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
    localparam logic       ASSERTED = SYNC_POL;
    localparam logic       IDLE_LVL = ~SYNC_POL;

    logic [2:0] div_q, div_d;
    logic       tick_q, tick_d;
    coord_t     x_q, x_d;
    coord_t     y_q, y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       vo_q, vo_d;
    logic       h_last, v_last;

    always_comb begin
        div_d  = (div_q == DIV_LAST) ? 3'd0 : div_q + 3'd1;
        tick_d = (div_d == DIV_LAST);
        h_last = (x_q == H_LAST);
        v_last = (y_q == V_LAST);
        x_d    = x_q;
        y_d    = y_q;
        if (tick_q) begin
            x_d = h_last ? '0 : x_q + coord_t'(1);
            if (h_last) begin
                y_d = v_last ? '0 : y_q + coord_t'(1);
            end
        end
        // Decode from the next count so sync stays coherent with pix_x/y.
        hs_d = in_span(x_d, HS_START, HS_END) ? ASSERTED : IDLE_LVL;
        vs_d = in_span(y_d, VS_START, VS_END) ? ASSERTED : IDLE_LVL;
        vo_d = (x_d < H_VIS_C) && (y_d < V_VIS_C);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            hs_q   <= IDLE_LVL;
            vs_q   <= IDLE_LVL;
            vo_q   <= 1'b1;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
            x_q    <= x_d;
            y_q    <= y_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            vo_q   <= vo_d;
        end
    end

    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign p_tick      = tick_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign video_on    = vo_q;
    assign frame_start = tick_q & h_last & v_last;

    sync_bus_t sync_now, sync_dly;

    assign sync_now = '{hsync: hs_q, vsync: vs_q, video_on: vo_q};

    if (PIPE_DLY == 0) begin : g_no_dly
        assign sync_dly = sync_now;
    end else begin : g_dly
        localparam sync_bus_t DLY_RST =
            '{hsync: IDLE_LVL, vsync: IDLE_LVL, video_on: 1'b0};

        sync_delay_line #(
            .DEPTH   (PIPE_DLY),
            .RST_VAL (DLY_RST)
        ) u_dly (
            .clk   (CLK),
            .rst_n (RESET),
            .en    (tick_q),
            .din   (sync_now),
            .dout  (sync_dly)
        );
    end

    assign hsync_d    = sync_dly.hsync;
    assign vsync_d    = sync_dly.vsync;
    assign video_on_d = sync_dly.video_on;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Three generator configurations checked every cycle against a tick-count
// model, with random asynchronous resets and a few literal timing pins.
module tb_vga_sync_gen;

    typedef struct {
        int hv, hf, hs, hb;
        int vv, vf, vs, vb;
        int div, dly, pol;
    } cfg_t;

    typedef struct {
        int px, py, pt, vo, hs, vs, hsd, vsd, vod, fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [9:0] px [3];
    logic [9:0] py [3];
    logic pt [3], vo [3], hs [3], vs [3];
    logic hsd [3], vsd [3], vod [3], fs [3];

    int n_chk = 0;
    int n_err = 0;
    int mc [3] = '{0, 0, 0};
    int mn [3] = '{0, 0, 0};
    bit running = 1'b0;
    bit measure = 1'b0;

    always #5 clk = ~clk;

    vga_sync_gen u_a (
        .CLK(clk), .RESET(rst_n),
        .pix_x(px[0]), .pix_y(py[0]), .p_tick(pt[0]),
        .video_on(vo[0]), .hsync(hs[0]), .vsync(vs[0]),
        .hsync_d(hsd[0]), .vsync_d(vsd[0]),
        .video_on_d(vod[0]), .frame_start(fs[0])
    );

    vga_sync_gen #(
        .CLK_DIV(4),
        .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .PIPE_DLY(3)
    ) u_b (
        .CLK(clk), .RESET(rst_n),
        .pix_x(px[1]), .pix_y(py[1]), .p_tick(pt[1]),
        .video_on(vo[1]), .hsync(hs[1]), .vsync(vs[1]),
        .hsync_d(hsd[1]), .vsync_d(vsd[1]),
        .video_on_d(vod[1]), .frame_start(fs[1])
    );

    vga_sync_gen #(
        .CLK_DIV(8),
        .H_VIS(10), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .PIPE_DLY(0)
    ) u_c (
        .CLK(clk), .RESET(rst_n),
        .pix_x(px[2]), .pix_y(py[2]), .p_tick(pt[2]),
        .video_on(vo[2]), .hsync(hs[2]), .vsync(vs[2]),
        .hsync_d(hsd[2]), .vsync_d(vsd[2]),
        .video_on_d(vod[2]), .frame_start(fs[2])
    );

    function automatic cfg_t cfg(input int k);
        cfg_t g;
        case (k)
            0: g = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 2, 0};
            1: g = '{16, 2, 3, 3, 8, 2, 2, 2, 4, 3, 1};
            default: g = '{10, 2, 2, 2, 6, 1, 2, 1, 8, 0, 0};
        endcase
        return g;
    endfunction

    // Sync levels for the pixel that is t ticks into a frame.
    function automatic void sig_at(
        input cfg_t g, input int t,
        output int o_vo, output int o_hs, output int o_vs
    );
        int htot, x, y;
        htot = g.hv + g.hf + g.hs + g.hb;
        x = t % htot;
        y = t / htot;
        o_vo = (x < g.hv && y < g.vv) ? 1 : 0;
        o_hs = (x >= g.hv + g.hf && x < g.hv + g.hf + g.hs)
             ? g.pol : 1 - g.pol;
        o_vs = (y >= g.vv + g.vf && y < g.vv + g.vf + g.vs)
             ? g.pol : 1 - g.pol;
    endfunction

    function automatic int tick_after(input cfg_t g, input int c);
        return (c >= 1 && (c % g.div) == g.div - 1) ? 1 : 0;
    endfunction

    // c = CLK edges since reset release, n = pixel ticks consumed.
    function automatic exp_t model(input int k, input int c, input int n);
        cfg_t g;
        exp_t e;
        int htot, vtot, ftot, t;
        g = cfg(k);
        htot = g.hv + g.hf + g.hs + g.hb;
        vtot = g.vv + g.vf + g.vs + g.vb;
        ftot = htot * vtot;
        t = n % ftot;
        e.px = t % htot;
        e.py = t / htot;
        e.pt = tick_after(g, c);
        sig_at(g, t, e.vo, e.hs, e.vs);
        e.fs = (e.pt == 1 && e.px == htot - 1 && e.py == vtot - 1)
             ? 1 : 0;
        if (n >= g.dly) begin
            sig_at(g, (n - g.dly) % ftot, e.vod, e.hsd, e.vsd);
        end else begin
            e.vod = 0;
            e.hsd = 1 - g.pol;
            e.vsd = 1 - g.pol;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int k,
                       input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %0d want %0d",
                     name, k, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                mc[k] = 0;
                mn[k] = 0;
            end else begin
                if (tick_after(cfg(k), mc[k]) == 1) mn[k] = mn[k] + 1;
                mc[k] = mc[k] + 1;
            end
        end
    end

    int cyc = 0;
    int a_fall = -1;
    int a_phs = 1;
    int a_phsd = 1;
    int b_fs = -1;
    int b_pt = -1;
    int b_pvs = 0;
    int b_rise = -1;

    always @(negedge clk) begin
        exp_t e;
        if (running) begin
            for (int k = 0; k < 3; k++) begin
                e = model(k, mc[k], mn[k]);
                chk("pix_x", k, int'(px[k]), e.px);
                chk("pix_y", k, int'(py[k]), e.py);
                chk("p_tick", k, int'(pt[k]), e.pt);
                chk("video_on", k, int'(vo[k]), e.vo);
                chk("hsync", k, int'(hs[k]), e.hs);
                chk("vsync", k, int'(vs[k]), e.vs);
                chk("hsync_d", k, int'(hsd[k]), e.hsd);
                chk("vsync_d", k, int'(vsd[k]), e.vsd);
                chk("video_on_d", k, int'(vod[k]), e.vod);
                chk("frame_start", k, int'(fs[k]), e.fs);
            end
        end
        if (measure) begin
            cyc++;
            if (int'(hs[0]) != a_phs) begin
                if (hs[0] == 1'b0) begin
                    if (a_fall >= 0) chk("a_line_len", 0, cyc - a_fall, 800);
                    chk("a_hs_start_x", 0, int'(px[0]), 656);
                    a_fall = cyc;
                end else begin
                    chk("a_hs_width", 0, cyc - a_fall, 96);
                    chk("a_hs_end_x", 0, int'(px[0]), 752);
                end
            end
            if (int'(hsd[0]) != a_phsd && hsd[0] == 1'b0) begin
                chk("a_hsd_lag", 0, cyc - a_fall, 2);
            end
            if (fs[1]) begin
                if (b_fs >= 0) chk("b_frame_len", 1, cyc - b_fs, 1344);
                b_fs = cyc;
            end
            if (pt[1]) begin
                if (b_pt >= 0) chk("b_tick_gap", 1, cyc - b_pt, 4);
                b_pt = cyc;
            end
            if (int'(vs[1]) != b_pvs) begin
                if (vs[1] == 1'b1) begin
                    chk("b_vs_start_y", 1, int'(py[1]), 10);
                    b_rise = cyc;
                end else if (b_rise >= 0) begin
                    chk("b_vs_width", 1, cyc - b_rise, 192);
                end
            end
            a_phs  = int'(hs[0]);
            a_phsd = int'(hsd[0]);
            b_pvs  = int'(vs[1]);
        end
    end

    initial begin
        int v, h, s;
        sig_at(cfg(0), 655, v, h, s);
        chk("pin_hs_655", 0, h, 1);
        sig_at(cfg(0), 656, v, h, s);
        chk("pin_hs_656", 0, h, 0);
        sig_at(cfg(0), 751, v, h, s);
        chk("pin_hs_751", 0, h, 0);
        sig_at(cfg(0), 752, v, h, s);
        chk("pin_hs_752", 0, h, 1);
        sig_at(cfg(0), 480 * 800, v, h, s);
        chk("pin_vo_y480", 0, v, 0);
        sig_at(cfg(0), 479 * 800 + 639, v, h, s);
        chk("pin_vo_last", 0, v, 1);
        sig_at(cfg(0), 490 * 800, v, h, s);
        chk("pin_vs_490", 0, s, 0);
        sig_at(cfg(0), 492 * 800, v, h, s);
        chk("pin_vs_492", 0, s, 1);

        running = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        measure = 1'b1;
        repeat (6000) @(posedge clk);
        #2 measure = 1'b0;

        for (int r = 0; r < 6; r++) begin
            @(posedge clk);
            #($urandom_range(1, 4)) rst_n = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #2 rst_n = 1'b1;
            repeat ($urandom_range(200, 3000)) @(posedge clk);
        end
        @(negedge clk);
        running = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator driving the VGA scan coordinates consumed by the character/graphics generator and producing the monitor sync signals. Walks an 800×525 frame (640×480 visible at 60 Hz) at one pixel per pixel tick. Publishes `pix_x`/`pix_y` immediately. Publishes copies of `hsync`/`vsync`/`video_on` delayed by a configurable number of pixel ticks, so they line up with the generator's registered, ROM-delayed `graph_rgb`.

## Interface
- `CLK_DIV`, default 1: CLK cycles per pixel tick; 1 means CLK is the 25 MHz pixel clock. Legal range 1–8.
- `H_VIS`, `H_FP`, `H_SYNC`, `H_BP`, defaults 640, 16, 96, 48: horizontal segment lengths in pixels.
- `V_VIS`, `V_FP`, `V_SYNC`, `V_BP`, defaults 480, 10, 2, 33: vertical segment lengths in lines.
- `SYNC_POL`, default 0: asserted level of `hsync`/`vsync`; 0 means active-low.
- `PIPE_DLY`, default 2: pixel-tick delay applied to `hsync_d`, `vsync_d`, `video_on_d`. Legal range 0–4.
- `CLK`, input, 1: system clock.
- `RESET`, input, 1: asynchronous, active-low reset.
- `pix_x`, output, 10: current horizontal count, 0–799.
- `pix_y`, output, 10: current vertical count, 0–524.
- `p_tick`, output, 1: one-CLK pulse marking each pixel advance.
- `video_on`, output, 1: high when `pix_x` < `H_VIS` and `pix_y` < `V_VIS`.
- `hsync`, `vsync`, output, 1 each: sync aligned to `pix_x`/`pix_y`.
- `hsync_d`, `vsync_d`, `video_on_d`, output, 1 each: the same signals delayed by `PIPE_DLY` pixel ticks. These drive the connector.
- `frame_start`, output, 1: one-CLK pulse, coincident with `p_tick`, on the tick where the counters move to (0,0).

## Operation
- Tick divider: a modulo-`CLK_DIV` counter. `p_tick` is high when the counter equals `CLK_DIV-1`. With `CLK_DIV`=1, `p_tick` is constantly high after reset release.
- Horizontal counter: on `p_tick`, increments and wraps from `H_TOT-1` (799) to 0.
- Vertical counter: advances only on a `p_tick` where the horizontal counter wraps. It wraps from `V_TOT-1` (524) to 0.
- `hsync` is asserted when `H_VIS+H_FP` ≤ `pix_x` < `H_VIS+H_FP+H_SYNC`, i.e. 656–751 at defaults.
- `vsync` is asserted when `V_VIS+V_FP` ≤ `pix_y` < `V_VIS+V_FP+V_SYNC`, i.e. 490–491 at defaults.
- Asserted level equals `SYNC_POL`; deasserted level is its inverse.
- `hsync`, `vsync` and `video_on` are registered. They are updated in the same CLK edge as the counters and decoded from the next count values, so they stay coherent with `pix_x`/`pix_y` on every cycle.
- Delay line: a `PIPE_DLY`-deep shift register of {hsync, vsync, video_on}, shifted only on `p_tick`. With `PIPE_DLY`=0, the `_d` outputs equal the undelayed signals.
- `frame_start` fires when both counters wrap on the same tick.
- Counter and comparison widths are 10 bits unsigned. The sum `H_TOT` = `H_VIS+H_FP+H_SYNC+H_BP` must be ≤ 1024, and likewise `V_TOT`. This is checked at elaboration.

## Timing
- Reset values:
  - Counters: `pix_x`=0, `pix_y`=0, tick divider=0.
  - `p_tick`=0, `frame_start`=0.
  - `video_on`=1, consistent with (0,0).
  - `hsync`, `vsync` and every delay-line stage = deasserted level, so `video_on_d`=0.
- Reset mid-frame: all state returns to the reset values asynchronously. The first `p_tick` after release advances to (1,0).
- Latency: `pix_x`/`pix_y` to `hsync`/`vsync`/`video_on` is 0 cycles. To the `_d` outputs it is `PIPE_DLY` pixel ticks.
- Period checks: line = 800 ticks, `hsync` pulse = 96 ticks, frame = 420 000 ticks, `vsync` pulse = 1600 ticks.
- Simultaneous wrap at (799,524) goes to (0,0) in one tick, with `frame_start` high for that one CLK cycle.
- No tick is ever dropped or duplicated.

## Structure
- Shared package `vga_pkg` holds:
  - the 640×480 segment constants;
  - derived `H_TOT`/`V_TOT` and sync start/end constants;
  - the 10-bit coordinate width.
- The same package is imported by the character/graphics generator for its box and text limits.
- One natural sub-module, `sync_delay_line`: a parameterised-depth, tick-enabled shift register for the three `_d` signals.

## Test plan
- **Reset release, defaults:** hold `RESET`=0 for 5 CLK, then release. `pix_x` counts 0,1,2,… every CLK. `hsync` first asserts at `pix_x`=656 and deasserts at 752.
- **Line and frame wrap:** run to (799,524). Next CLK gives (0,0), a one-cycle `frame_start` pulse, and `video_on`=1. Frame length is exactly 420 000 CLK.
- **Vertical sync:** `vsync` is low for `pix_y` 490–491 only, a width of exactly 1600 CLK. `video_on` is low for all `pix_y` ≥ 480.
- **Delay alignment:** with `PIPE_DLY`=2, `hsync_d` falls exactly 2 ticks after `hsync`. `video_on_d` rises 2 ticks after (0,0).
- **Divider:** with `CLK_DIV`=4, `p_tick` is high 1 cycle in every 4. `pix_x` holds for 4 CLK per value. A line is 3200 CLK.
- **Mid-frame reset:** assert `RESET` at (300,200) for 3 CLK. Outputs immediately go to the reset values. After release, counting restarts from (0,0) and `frame_start` next fires 420 000 ticks later.
